// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int          DEF_PAT_W     = 4;
    localparam int          DEF_CNT_W     = 8;
    localparam logic [3:0]  DEF_PAT_RESET = 4'b1101;

    // Width needed to hold a fill count from 0 up to and including pat_w.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + W'(1);
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, optional overlap and a
// saturating match counter; y is a registered one-cycle match pulse.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(DEF_PAT_RESET),
    parameter int               CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             y,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             FW   = fill_w(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] hist_next;
    logic [FW-1:0]    fill_next;
    logic             hit;

    // A match is decided on the history as it will look after this bit.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], x};
        fill_next = (fill == FULL) ? FULL : fill + FW'(1);
        hit       = x_valid && !pat_load && (fill_next == FULL) && (hist_next == pat);
    end

    always_ff @(posedge clk) begin
        if (reset)
            pat <= PAT_RESET;
        else if (pat_load)
            pat <= pat_in;
    end

    always_ff @(posedge clk) begin
        if (reset || pat_load) begin
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= hist_next;
            fill <= (hit && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            y <= 1'b0;
        else
            y <= hit;
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .q     (match_cnt)
    );

    assign armed = (fill == FULL);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded random/directed bench for seq_detector_param; a second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_seq_detector_param;

    typedef struct packed {
        logic       y;
        logic       armed;
        logic [7:0] cnt;
        logic [1:0] cnt_s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0;
    logic       y, armed, y_s, armed_s;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_s;

    exp_t exp_q[$];
    int   m_bits[$];
    logic [3:0] m_pat = 4'b1101;
    int   m_matches = 0;
    int   checks = 0;
    int   passes = 0;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .y(y), .armed(armed), .match_cnt(match_cnt)
    );

    seq_detector_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .y(y_s), .armed(armed_s), .match_cnt(match_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input int act, input int req);
        checks++;
        if (act == req)
            passes++;
        else
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    task automatic checkOutput(input exp_t e);
        check1("y", int'(y), int'(e.y));
        check1("armed", int'(armed), int'(e.armed));
        check1("match_cnt", int'(match_cnt), int'(e.cnt));
        check1("y_sat", int'(y_s), int'(e.y));
        check1("armed_sat", int'(armed_s), int'(e.armed));
        check1("match_cnt_sat", int'(match_cnt_s), int'(e.cnt_s));
    endtask

    // Reference model: keeps the most recent valid bits since the last
    // reset, pattern load or non-overlapping match, and compares them
    // bit by bit against the pattern, oldest bit against the MSB.
    task automatic applyStimulus(input logic r, input logic xv, input logic xb,
                                 input logic ov, input logic pl, input logic [3:0] pin);
        exp_t e;
        logic hit;
        @(negedge clk);
        reset = r; x_valid = xv; x = xb; overlap = ov; pat_load = pl; pat_in = pin;
        hit = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat = 4'b1101;
            m_matches = 0;
        end else if (pl) begin
            m_pat = pin;
            m_bits.delete();
        end else if (xv) begin
            m_bits.push_back(int'(xb));
            if (m_bits.size() > 4) void'(m_bits.pop_front());
            if (m_bits.size() == 4) begin
                hit = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_bits[i] != int'(m_pat[3-i])) hit = 1'b0;
            end
            if (hit) begin
                m_matches++;
                if (!ov) m_bits.delete();
            end
        end
        e.y     = hit;
        e.armed = (m_bits.size() == 4);
        e.cnt   = 8'((m_matches > 255) ? 255 : m_matches);
        e.cnt_s = 2'((m_matches > 3) ? 3 : m_matches);
        exp_q.push_back(e);
    endtask

    task automatic sendBit(input logic b, input logic ov);
        applyStimulus(1'b0, 1'b1, b, ov, 1'b0, 4'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    // Monitor: every edge the DUT presents a fresh registered output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        logic [6:0] s7;
        logic [3:0] s4;
        logic       ov;
        s7 = 7'b1101101;
        s4 = 4'b1101;

        doReset();
        doReset();
        for (int i = 6; i >= 0; i--) sendBit(s7[i], 1'b1);

        doReset();
        for (int i = 6; i >= 0; i--) sendBit(s7[i], 1'b0);

        doReset();
        for (int i = 3; i >= 0; i--) begin
            sendBit(s4[i], 1'b1);
            applyStimulus(1'b0, 1'b0, 1'(i), 1'b1, 1'b0, 4'b0);
            applyStimulus(1'b0, 1'b0, ~1'(i), 1'b1, 1'b0, 4'b0);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110);
        s4 = 4'b0110;
        for (int i = 3; i >= 0; i--) sendBit(s4[i], 1'b1);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 8; i++) sendBit(1'b1, 1'b1);

        doReset();
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        doReset();
        sendBit(1'b1, 1'b1);
        s4 = 4'b1101;
        for (int i = 3; i >= 0; i--) sendBit(s4[i], 1'b1);

        ov = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) ov = ~ov;
            if ($urandom_range(0, 149) == 0)
                doReset();
            else if ($urandom_range(0, 59) == 0)
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), ov, 1'b1, 4'($urandom));
            else
                applyStimulus(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), ov, 1'b0, 4'b0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0);
        @(negedge clk);
        @(negedge clk);
        check1("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
